// File: rtl/mhd_partition_monitor_if.sv
// Bus between the MHD monitor and the partition harness.
// Carries control, stimulus, partition outputs and results.
interface mhd_partition_monitor_if #(
    parameter int NUM_PI = 5,
    parameter int NUM_PO = 3,
    parameter int CNT_W  = 16
);
    localparam int MW = $clog2(NUM_PO + 1);

    logic              start;
    logic              mode;
    logic [NUM_PI-1:0] pi;
    logic [NUM_PO-1:0] po_exact;
    logic [NUM_PO-1:0] po_approx;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  hd_sum;
    logic [CNT_W-1:0]  err_cnt;
    logic [MW-1:0]     max_hd;
    logic [CNT_W-1:0]  samples;

    modport master (
        output start, mode, po_exact, po_approx,
        input  pi, busy, done, hd_sum, err_cnt, max_hd, samples
    );

    modport slave (
        input  start, mode, po_exact, po_approx,
        output pi, busy, done, hd_sum, err_cnt, max_hd, samples
    );
endinterface

// File: rtl/mhd_partition_monitor.sv
// Hamming-distance error harness for approximate partitions.
// Sweeps exhaustive or LFSR stimulus and accumulates distance.
module mhd_partition_monitor #(
    parameter int          NUM_PI      = 5,
    parameter int          NUM_PO      = 3,
    parameter int          CNT_W       = 16,
    parameter int          NUM_SAMPLES = 1000,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    rst,
    mhd_partition_monitor_if.slave  bus
);
    localparam int MW = $clog2(NUM_PO + 1);
    localparam int EW = CNT_W + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [15:0]       TAPS    = 16'hB400;
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [NUM_PI-1:0] PI_LAST = '1;
    localparam logic [CNT_W-1:0]  SMP_END = CNT_W'(NUM_SAMPLES - 1);

    logic [1:0]        r_state;
    logic              r_mode;
    logic [15:0]       r_pat;
    logic [NUM_PI-1:0] r_pi;
    logic [CNT_W-1:0]  r_hd_sum;
    logic [CNT_W-1:0]  r_err_cnt;
    logic [MW-1:0]     r_max_hd;
    logic [CNT_W-1:0]  r_samples;

    logic [NUM_PO-1:0] w_diff;
    logic [MW-1:0]     w_d;
    logic [EW-1:0]     w_hd_ext;
    logic [CNT_W-1:0]  w_hd_nxt;
    logic [CNT_W-1:0]  w_err_nxt;
    logic [CNT_W-1:0]  w_smp_nxt;
    logic [MW-1:0]     w_max_nxt;
    logic              w_last;
    logic              w_go;
    logic [15:0]       w_first;

    // Next pattern: Galois LFSR shift in random mode, +1 otherwise.
    function automatic logic [15:0] f_step(
        input logic        m,
        input logic [15:0] v
    );
        if (m)
            return {1'b0, v[15:1]} ^ (v[0] ? TAPS : 16'h0000);
        else
            return v + 16'd1;
    endfunction

    // Per-pattern distance and saturating next-result values.
    always_comb begin
        w_diff = bus.po_exact ^ bus.po_approx;
        w_d    = '0;
        for (int i = 0; i < NUM_PO; i++)
            w_d = w_d + MW'(w_diff[i]);

        w_hd_ext = {1'b0, r_hd_sum} + EW'(w_d);
        w_hd_nxt = w_hd_ext[CNT_W] ? CNT_MAX : w_hd_ext[CNT_W-1:0];

        w_err_nxt = r_err_cnt;
        if (w_d != '0 && r_err_cnt != CNT_MAX)
            w_err_nxt = r_err_cnt + 1'b1;

        w_smp_nxt = r_samples;
        if (r_samples != CNT_MAX)
            w_smp_nxt = r_samples + 1'b1;

        w_max_nxt = (w_d > r_max_hd) ? w_d : r_max_hd;

        w_last  = r_mode ? (r_samples == SMP_END) : (r_pi == PI_LAST);
        w_go    = bus.start && (r_state != S_RUN);
        w_first = bus.mode ? LFSR_SEED : 16'h0000;
    end

    // Sweep FSM, stimulus generation and result accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_mode    <= 1'b0;
            r_pat     <= LFSR_SEED;
            r_pi      <= '0;
            r_hd_sum  <= '0;
            r_err_cnt <= '0;
            r_max_hd  <= '0;
            r_samples <= '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    r_hd_sum  <= w_hd_nxt;
                    r_err_cnt <= w_err_nxt;
                    r_max_hd  <= w_max_nxt;
                    r_samples <= w_smp_nxt;
                    if (w_last) begin
                        r_state <= S_DONE;
                    end else begin
                        r_pi  <= r_pat[NUM_PI-1:0];
                        r_pat <= f_step(r_mode, r_pat);
                    end
                end
                S_IDLE, S_DONE: begin
                    if (w_go) begin
                        r_state   <= S_RUN;
                        r_mode    <= bus.mode;
                        r_pi      <= w_first[NUM_PI-1:0];
                        r_pat     <= f_step(bus.mode, w_first);
                        r_hd_sum  <= '0;
                        r_err_cnt <= '0;
                        r_max_hd  <= '0;
                        r_samples <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.pi      = r_pi;
    assign bus.busy    = (r_state == S_RUN);
    assign bus.done    = (r_state == S_DONE);
    assign bus.hd_sum  = r_hd_sum;
    assign bus.err_cnt = r_err_cnt;
    assign bus.max_hd  = r_max_hd;
    assign bus.samples = r_samples;
endmodule

// File: tb/tb_mhd_partition_monitor.sv
// Scoreboard bench for mhd_partition_monitor.
// Expected pi and results are queued; monitors pop and compare.
module tb_mhd_partition_monitor;
    typedef struct {
        int hd;
        int err;
        int mx;
        int smp;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   t0 = 0;
    logic [1:0] apx = 2'd0;
    logic done0_q = 1'b0;
    logic done1_q = 1'b0;

    int   pi_q[$];
    res_t res_q[$];
    res_t res1_q[$];

    mhd_partition_monitor_if #(.NUM_PI(5), .NUM_PO(3), .CNT_W(16)) b0 ();
    mhd_partition_monitor_if #(.NUM_PI(5), .NUM_PO(3), .CNT_W(4))  b1 ();

    mhd_partition_monitor #(
        .NUM_PI(5), .NUM_PO(3), .CNT_W(16),
        .NUM_SAMPLES(10), .LFSR_SEED(16'hACE1)
    ) u0 (
        .clk(clk), .rst(rst), .bus(b0)
    );

    mhd_partition_monitor #(
        .NUM_PI(5), .NUM_PO(3), .CNT_W(4),
        .NUM_SAMPLES(10), .LFSR_SEED(16'hACE1)
    ) u1 (
        .clk(clk), .rst(rst), .bus(b1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2:0] fexact(input logic [4:0] p);
        return {p[4] ^ p[3], p[2] & p[1], p[0] | p[4]};
    endfunction

    always_comb begin
        b0.po_exact = fexact(b0.pi);
        case (apx)
            2'd0:    b0.po_approx = b0.po_exact;
            2'd1:    b0.po_approx = ~b0.po_exact;
            default: b0.po_approx = b0.po_exact ^ {2'b00, b0.pi[0]};
        endcase
        b1.po_exact  = fexact(b1.pi);
        b1.po_approx = ~b1.po_exact;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_res(input string tag, input res_t e,
                           input int hd, input int er,
                           input int mx, input int sm);
        chk({tag, "_hd_sum"}, hd, e.hd);
        chk({tag, "_err_cnt"}, er, e.err);
        chk({tag, "_max_hd"}, mx, e.mx);
        chk({tag, "_samples"}, sm, e.smp);
    endtask

    // Monitor for instance 0: pi each RUN cycle, results on done rise.
    always @(negedge clk) begin
        if (b0.busy) begin
            if (pi_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pi_extra: got %0d expected none", b0.pi);
            end else begin
                chk("pi", int'(b0.pi), pi_q.pop_front());
            end
        end
        if (b0.done && !done0_q) begin
            if (res_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL res_extra: got done expected none");
            end else begin
                chk_res("u0", res_q.pop_front(), int'(b0.hd_sum),
                        int'(b0.err_cnt), int'(b0.max_hd),
                        int'(b0.samples));
            end
        end
        done0_q = b0.done;
    end

    // Monitor for the narrow-counter instance.
    always @(negedge clk) begin
        if (b1.done && !done1_q) begin
            if (res1_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL res1_extra: got done expected none");
            end else begin
                chk_res("u1", res1_q.pop_front(), int'(b1.hd_sum),
                        int'(b1.err_cnt), int'(b1.max_hd),
                        int'(b1.samples));
            end
        end
        done1_q = b1.done;
    end

    task automatic push_exh(input int n);
        for (int i = 0; i < n; i++) pi_q.push_back(i);
    endtask

    task automatic push_rnd();
        int tbl[10] = '{1, 16, 24, 28, 14, 7, 19, 9, 4, 2};
        for (int i = 0; i < 10; i++) pi_q.push_back(tbl[i]);
    endtask

    task automatic push_res(input int hd, input int er,
                            input int mx, input int sm);
        res_t r;
        r.hd = hd; r.err = er; r.mx = mx; r.smp = sm;
        res_q.push_back(r);
    endtask

    task automatic go0(input logic m);
        @(posedge clk);
        #2;
        b0.start = 1'b1;
        b0.mode  = m;
        @(posedge clk);
        #2;
        t0 = cyc;
        b0.start = 1'b0;
    endtask

    task automatic wait0(input string name, input int lat);
        while (!b0.done && (cyc - t0) < 300) begin
            @(posedge clk);
            #1;
        end
        chk(name, cyc - t0 + 1, lat);
    endtask

    initial begin
        res_t r1;
        b0.start = 1'b0;
        b0.mode  = 1'b0;
        b1.start = 1'b0;
        b1.mode  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_pi", int'(b0.pi), 0);
        chk("rst_busy", int'(b0.busy), 0);
        chk("rst_done", int'(b0.done), 0);
        chk("rst_sums", int'(b0.hd_sum) + int'(b0.err_cnt)
            + int'(b0.max_hd) + int'(b0.samples), 0);
        chk("rst1_done", int'(b1.done) + int'(b1.busy), 0);
        rst = 1'b0;

        apx = 2'd0;
        push_exh(32);
        push_res(0, 0, 0, 32);
        go0(1'b0);
        chk("busy_after_start", int'(b0.busy), 1);
        wait0("lat_tie", 33);

        apx = 2'd1;
        push_exh(32);
        push_res(96, 32, 3, 32);
        go0(1'b0);
        wait0("lat_inv", 33);
        chk("pi_hold_exh", int'(b0.pi), 31);

        apx = 2'd2;
        push_exh(32);
        push_res(16, 16, 1, 32);
        go0(1'b0);
        wait0("lat_xor", 33);

        apx = 2'd1;
        push_rnd();
        push_res(30, 10, 3, 10);
        go0(1'b1);
        wait0("lat_rnd", 11);
        repeat (2) @(posedge clk);
        #1;
        chk("pi_hold_rnd", int'(b0.pi), 2);
        chk("done_hold", int'(b0.done), 1);

        push_rnd();
        push_res(30, 10, 3, 10);
        go0(1'b1);
        wait0("lat_rnd_restart", 11);

        push_exh(32);
        push_res(96, 32, 3, 32);
        go0(1'b0);
        repeat (5) @(posedge clk);
        #2;
        b0.start = 1'b1;
        b0.mode  = 1'b1;
        @(posedge clk);
        #2;
        b0.start = 1'b0;
        b0.mode  = 1'b0;
        wait0("lat_pulse", 33);

        apx = 2'd0;
        push_exh(11);
        go0(1'b0);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", int'(b0.busy), 0);
        chk("abort_done", int'(b0.done), 0);
        chk("abort_pi", int'(b0.pi), 0);
        chk("abort_hd", int'(b0.hd_sum), 0);
        chk("abort_samples", int'(b0.samples), 0);
        rst = 1'b0;

        r1.hd = 15; r1.err = 15; r1.mx = 3; r1.smp = 15;
        res1_q.push_back(r1);
        @(posedge clk);
        #2;
        b1.start = 1'b1;
        @(posedge clk);
        #2;
        t0 = cyc;
        b1.start = 1'b0;
        while (!b1.done && (cyc - t0) < 300) begin
            @(posedge clk);
            #1;
        end
        chk("lat_sat", cyc - t0 + 1, 33);

        repeat (3) @(posedge clk);
        #1;
        chk("pi_q_left", pi_q.size(), 0);
        chk("res_q_left", res_q.size() + res1_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
